// File: rtl/trap_pkg.sv
// trap_pkg: shared types and trap codes for the trap arbiter
package trap_pkg;
    localparam int XLEN = 32;
    localparam logic [4:0] IRQ_CODE_MEI = 5'd11;
    localparam logic [4:0] IRQ_CODE_MSI = 5'd3;
    localparam logic [4:0] IRQ_CODE_MTI = 5'd7;
    localparam logic [4:0] CAUSE_UNUSED = 5'd31;
    typedef logic [XLEN-1:0] trap_cause_t;
    typedef enum logic {IDLE, PENDING} trap_state_t;
endpackage

// File: rtl/trap_lane_select.sv
// trap_lane_select: lowest-set-bit priority encoder returning {valid, index}
module trap_lane_select #(
    parameter int W = 5,
    localparam int IW = W > 1 ? $clog2(W) : 1
) (
    input  logic [W-1:0]  req,
    output logic          valid,
    output logic [IW-1:0] idx
);
    always_comb begin
        idx = '0;
        for (int i = W - 1; i >= 0; i--)
            idx = req[i] ? IW'(i) : idx;
    end
    assign valid = |req;
endmodule

// File: rtl/trap_arbiter.sv
// trap_arbiter: fixed-priority exception/interrupt arbiter latching one trap until ack.
// Optional TRAP_STATS_EN adds exception/interrupt entry counters.
module trap_arbiter
    import trap_pkg::*;
#(
    parameter int LANES = 2,
    parameter int CAUSES = 5,
    parameter int XLEN = 32,
    parameter logic [LANES-1:0][CAUSES-1:0][4:0] CAUSE_MAP =
        {5'd31, 5'd7, 5'd5, 5'd6, 5'd4, 5'd11, 5'd3, 5'd2, 5'd1, 5'd0},
    localparam int LW = LANES > 1 ? $clog2(LANES) : 1
) (
    input  logic                              i_clk,
    input  logic                              i_rst_n,
    input  logic [LANES-1:0][CAUSES-1:0]      i_lane_err,
    input  logic [LANES-1:0][XLEN-1:0]        i_lane_pc,
    input  logic [LANES-1:0][XLEN-1:0]        i_lane_tval,
    input  logic [2:0]                        i_irq,
    input  logic [2:0]                        i_irq_mask,
    input  logic                              i_irq_en,
    input  logic                              i_trap_ack,
    output logic                              o_trap_valid,
    output logic [XLEN-1:0]                   o_trap_cause,
    output logic [XLEN-1:0]                   o_trap_pc,
    output logic [XLEN-1:0]                   o_trap_tval,
    output logic [LW-1:0]                     o_trap_lane,
    output logic [LANES-1:0]                  o_flush
`ifdef TRAP_STATS_EN
    ,
    output logic [31:0]                       o_exc_count,
    output logic [31:0]                       o_irq_count
`endif
);
    localparam int CW = CAUSES > 1 ? $clog2(CAUSES) : 1;

    logic [LANES-1:0]          lane_vld, lane_rev;
    logic [LANES-1:0][CW-1:0]  lane_idx;
    logic                      exc_any, irq_take, take;
    logic [LW-1:0]             rev_idx, win;
    logic [2:0]                irq_pend;
    logic [4:0]                irq_code, exc_code;
    trap_state_t               state, state_d;

    genvar l;
    for (l = 0; l < LANES; l++) begin : g_lane
        trap_lane_select #(.W(CAUSES)) u_sel (
            .req  (i_lane_err[l]),
            .valid(lane_vld[l]),
            .idx  (lane_idx[l])
        );
        assign lane_rev[l] = lane_vld[LANES-1-l];
    end

    // reversed so the lowest-bit encoder picks the oldest (highest-index) lane
    trap_lane_select #(.W(LANES)) u_lane (
        .req  (lane_rev),
        .valid(exc_any),
        .idx  (rev_idx)
    );

    assign win      = LW'(LANES - 1) - rev_idx;
    assign exc_code = CAUSE_MAP[win][lane_idx[win]];
    assign irq_pend = i_irq & i_irq_mask;
    assign irq_take = i_irq_en && |irq_pend && !exc_any;
    assign irq_code = irq_pend[2] ? IRQ_CODE_MEI : irq_pend[0] ? IRQ_CODE_MSI : IRQ_CODE_MTI;
    assign take     = exc_any || irq_take;

    always_comb begin
        state_d = state;
        state_d = state == IDLE ? (take ? PENDING : IDLE) : (i_trap_ack ? IDLE : PENDING);
    end

    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state        <= IDLE;
            o_trap_cause <= '0;
            o_trap_pc    <= '0;
            o_trap_tval  <= '0;
            o_trap_lane  <= '0;
            o_flush      <= '0;
        end else begin
            state   <= state_d;
            o_flush <= '0;
            if (state == IDLE && take) begin
                o_trap_cause <= exc_any ? XLEN'(exc_code) : {1'b1, (XLEN-1)'(irq_code)};
                o_trap_pc    <= exc_any ? i_lane_pc[win] : i_lane_pc[LANES-1];
                o_trap_tval  <= exc_any ? i_lane_tval[win] : '0;
                o_trap_lane  <= exc_any ? win : '0;
                o_flush      <= exc_any ? {LANES{1'b1}} >> (LANES - 1 - int'(win)) : '1;
            end
        end
    end

    assign o_trap_valid = state == PENDING;

`ifdef TRAP_STATS_EN
    always_ff @(posedge i_clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            o_exc_count <= '0;
            o_irq_count <= '0;
        end else if (state == IDLE) begin
            o_exc_count <= o_exc_count + 32'(exc_any);
            o_irq_count <= o_irq_count + 32'(irq_take);
        end
    end
`endif
endmodule
